cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter TAG_W, default 6, width of the physical-register tag.
REQ-002 Parameter DATA_W, default 32, width of the result data.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 int_req, ls_req, mult_req, div_req  input  1 each  requester has a result pending; held high until granted.
REQ-006 int_tag, ls_tag, mult_tag, div_tag  input  TAG_W each  destination tag of the pending result; stable while req is high.
REQ-007 int_data, ls_data, mult_data, div_data  input  DATA_W each  pending result data; stable while req is high.
REQ-008 int_branch, int_branch_taken  input  1 each  the integer result is a resolved branch, and its outcome.
REQ-009 int_gnt, ls_gnt, mult_gnt, div_gnt  output  1 each  combinational grant, one-hot or zero.
REQ-010 cdb_valid  output  1  registered broadcast valid.
REQ-011 cdb_tag  output  TAG_W  registered broadcast tag.
REQ-012 cdb_data  output  DATA_W  registered broadcast data.
REQ-013 cdb_branch, cdb_branch_taken  output  1 each  registered branch-resolution flags.

Function
REQ-014 Requester index order SHALL be: 0 = int, 1 = ls, 2 = mult, 3 = div.
REQ-015 At most one grant SHALL be asserted per cycle; with no request asserted, all grants SHALL be 0.
REQ-016 A grant SHALL be asserted only to a requester whose req is high in the same cycle; grant depends on req and the pointer only, never on tag or data.
REQ-017 A requester SHALL drop or replace its req/payload in the cycle after it sees its grant; the payload is transferred in the grant cycle.
REQ-018 On the clock edge ending a grant cycle, cdb_valid <= 1 and cdb_tag/cdb_data <= the granted payload; latency from grant to broadcast is exactly 1 cycle.
REQ-019 cdb_branch/cdb_branch_taken SHALL load int_branch/int_branch_taken when int is granted, and 0 otherwise.
REQ-020 On a cycle with no grant, cdb_valid <= 0, cdb_branch <= 0 and cdb_branch_taken <= 0; cdb_tag/cdb_data SHALL hold their previous values.
REQ-021 Priority pointer last_gnt (2 bits): the search for a grant starts at (last_gnt+1) mod 4 and wraps 3->0.
REQ-022 last_gnt SHALL update to the granted index on every grant cycle, and hold otherwise.
REQ-023 With all four requesters continuously requesting, the grant sequence SHALL be int, ls, mult, div, int, ...; no requester waits more than 3 cycles.
REQ-024 Back-to-back grants SHALL be allowed, giving one broadcast per cycle at full throughput.

Reset
REQ-025 While reset is high: cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_branch=0, cdb_branch_taken=0, last_gnt=3; all grants are forced to 0 regardless of req.
REQ-026 Assertion of reset mid-operation SHALL discard any grant in that cycle with no broadcast.
REQ-027 After reset deasserts, the first arbitration SHALL start at int.

Configuration
REQ-028 Macro CDB_ARB_RR_EN: when defined, round-robin per REQ-021..REQ-023 applies.
REQ-029 When CDB_ARB_RR_EN is undefined: fixed priority div > mult > ls > int, last_gnt is removed, and the starvation bound of REQ-023 does not apply; all other requirements are unchanged.

Verification
REQ-030 After reset release, int_req=1 with tag 0x05, data 0xDEADBEEF -> int_gnt=1 that cycle; next cycle cdb_valid=1, cdb_tag=0x05, cdb_data=0xDEADBEEF; following cycle cdb_valid=0.
REQ-031 RR build, all four req held high for 8 cycles -> grants int, ls, mult, div, int, ls, mult, div; cdb_valid=1 for 8 consecutive cycles, with tags in the same order.
REQ-032 int_req=1, int_branch=1, int_branch_taken=1 -> next cycle cdb_branch=1, cdb_branch_taken=1; ls granted next -> cdb_branch=0 on its broadcast.
REQ-033 Fixed-priority build, ls_req and div_req both high for 2 cycles -> div granted, then ls; no grant while only a non-winning request is waiting on the same cycle as div.
REQ-034 reset pulsed high for half a cycle while mult_req=1 and mult_gnt=1 -> outputs go to 0 immediately, no broadcast occurs, and the first grant after release goes by order from int.
REQ-035 No requests for 5 cycles -> all grants 0, cdb_valid=0, and cdb_tag/cdb_data hold their last values.

Source files
------------

// File: rtl/cdb_arbiter.sv
// ============================================================================
// Module   : cdb_arbiter
// Purpose  : Four-way common-data-bus arbiter with registered broadcast.
//            Define CDB_ARB_RR_EN for round-robin; default is fixed priority.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cdb_arbiter #(
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              int_req,
    input  logic              ls_req,
    input  logic              mult_req,
    input  logic              div_req,
    input  logic [TAG_W-1:0]  int_tag,
    input  logic [TAG_W-1:0]  ls_tag,
    input  logic [TAG_W-1:0]  mult_tag,
    input  logic [TAG_W-1:0]  div_tag,
    input  logic [DATA_W-1:0] int_data,
    input  logic [DATA_W-1:0] ls_data,
    input  logic [DATA_W-1:0] mult_data,
    input  logic [DATA_W-1:0] div_data,
    input  logic              int_branch,
    input  logic              int_branch_taken,
    output logic              int_gnt,
    output logic              ls_gnt,
    output logic              mult_gnt,
    output logic              div_gnt,
    output logic              cdb_valid,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_data,
    output logic              cdb_branch,
    output logic              cdb_branch_taken
);

    logic [3:0] w_req;
    logic [3:0] w_gnt_raw;
    logic [3:0] w_gnt;

    assign w_req = {div_req, mult_req, ls_req, int_req};

`ifdef CDB_ARB_RR_EN
    logic [1:0] last_gnt_q;
    logic [1:0] last_gnt_d;

    // Search starts one past the last winner and wraps 3 -> 0.
    always_comb begin
        logic [1:0] w_idx;
        logic       w_found;
        w_gnt_raw = 4'b0000;
        w_found   = 1'b0;
        w_idx     = 2'd0;
        for (int k = 0; k < 4; k++) begin
            w_idx = last_gnt_q + 2'(k + 1);
            if (!w_found && w_req[w_idx]) begin
                w_gnt_raw[w_idx] = 1'b1;
                w_found          = 1'b1;
            end
        end
    end

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (w_gnt[0]) last_gnt_d = 2'd0;
        if (w_gnt[1]) last_gnt_d = 2'd1;
        if (w_gnt[2]) last_gnt_d = 2'd2;
        if (w_gnt[3]) last_gnt_d = 2'd3;
    end

    // Reset value 3 makes the first search after reset begin at int.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_gnt_q <= 2'd3;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end
`else
    always_comb begin
        w_gnt_raw = 4'b0000;
        if (w_req[3])      w_gnt_raw = 4'b1000;
        else if (w_req[2]) w_gnt_raw = 4'b0100;
        else if (w_req[1]) w_gnt_raw = 4'b0010;
        else if (w_req[0]) w_gnt_raw = 4'b0001;
    end
`endif

    assign w_gnt    = reset ? 4'b0000 : w_gnt_raw;
    assign int_gnt  = w_gnt[0];
    assign ls_gnt   = w_gnt[1];
    assign mult_gnt = w_gnt[2];
    assign div_gnt  = w_gnt[3];

    logic              valid_q,  valid_d;
    logic [TAG_W-1:0]  tag_q,    tag_d;
    logic [DATA_W-1:0] data_q,   data_d;
    logic              br_q,     br_d;
    logic              taken_q,  taken_d;

    // Tag and data hold on idle cycles; only valid and branch flags clear.
    always_comb begin
        valid_d = |w_gnt;
        tag_d   = tag_q;
        data_d  = data_q;
        br_d    = 1'b0;
        taken_d = 1'b0;
        if (w_gnt[0]) begin
            tag_d   = int_tag;
            data_d  = int_data;
            br_d    = int_branch;
            taken_d = int_branch_taken;
        end else if (w_gnt[1]) begin
            tag_d  = ls_tag;
            data_d = ls_data;
        end else if (w_gnt[2]) begin
            tag_d  = mult_tag;
            data_d = mult_data;
        end else if (w_gnt[3]) begin
            tag_d  = div_tag;
            data_d = div_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
            br_q    <= 1'b0;
            taken_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
            br_q    <= br_d;
            taken_q <= taken_d;
        end
    end

    assign cdb_valid        = valid_q;
    assign cdb_tag          = tag_q;
    assign cdb_data         = data_q;
    assign cdb_branch       = br_q;
    assign cdb_branch_taken = taken_q;

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
// ============================================================================
// Module   : tb_cdb_arbiter
// Purpose  : Self-checking bench for cdb_arbiter with a priority-list model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cdb_arbiter;
    localparam int TAG_W  = 6;
    localparam int DATA_W = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [TAG_W-1:0]  tag [4];
    logic [DATA_W-1:0] dat [4];
    logic int_branch = 1'b0;
    logic int_branch_taken = 1'b0;

    logic int_gnt, ls_gnt, mult_gnt, div_gnt;
    logic cdb_valid, cdb_branch, cdb_branch_taken;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic [3:0] gnt_v;

    int checks = 0;
    int errors = 0;

    assign gnt_v = {div_gnt, mult_gnt, ls_gnt, int_gnt};

    cdb_arbiter #(.TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .int_req(req[0]), .ls_req(req[1]), .mult_req(req[2]), .div_req(req[3]),
        .int_tag(tag[0]), .ls_tag(tag[1]), .mult_tag(tag[2]), .div_tag(tag[3]),
        .int_data(dat[0]), .ls_data(dat[1]), .mult_data(dat[2]), .div_data(dat[3]),
        .int_branch(int_branch), .int_branch_taken(int_branch_taken),
        .int_gnt(int_gnt), .ls_gnt(ls_gnt), .mult_gnt(mult_gnt), .div_gnt(div_gnt),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .cdb_branch(cdb_branch), .cdb_branch_taken(cdb_branch_taken)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the winner is the first requester in a priority list.
    int                m_last  = 3;
    logic              m_valid = 1'b0;
    logic [TAG_W-1:0]  m_tag   = '0;
    logic [DATA_W-1:0] m_data  = '0;
    logic              m_br    = 1'b0;
    logic              m_taken = 1'b0;

    function automatic int model_pick();
        int c;
        if (reset) return -1;
        for (int k = 0; k < 4; k++) begin
`ifdef CDB_ARB_RR_EN
            c = (m_last + 1 + k) % 4;
`else
            c = 3 - k;
`endif
            if (req[c]) return c;
        end
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [3:0] g);
        for (int i = 0; i < 4; i++) if (g == (4'b0001 << i)) return i;
        return -1;
    endfunction

    always @(posedge clk or posedge reset) begin
        int g;
        if (reset) begin
            m_last = 3; m_valid = 0; m_tag = '0; m_data = '0; m_br = 0; m_taken = 0;
        end else begin
            g = model_pick();
            if (g >= 0) begin
                m_valid = 1;
                m_tag   = tag[g];
                m_data  = dat[g];
                m_br    = (g == 0) ? int_branch : 1'b0;
                m_taken = (g == 0) ? int_branch_taken : 1'b0;
                m_last  = g;
            end else begin
                m_valid = 0; m_br = 0; m_taken = 0;
            end
        end
    end

    always @(negedge clk) begin
        int g;
        g = model_pick();
        chk("gnt", 64'(gnt_v), (g < 0) ? 64'd0 : 64'(4'b0001 << g));
        chk("cdb_valid", 64'(cdb_valid), 64'(m_valid));
        chk("cdb_tag", 64'(cdb_tag), 64'(m_tag));
        chk("cdb_data", 64'(cdb_data), 64'(m_data));
        chk("cdb_branch", 64'(cdb_branch), 64'(m_br));
        chk("cdb_branch_taken", 64'(cdb_branch_taken), 64'(m_taken));
    end

    task automatic tick(); @(posedge clk); #1; endtask
    task automatic mid();  @(negedge clk); #1; endtask

    task automatic do_reset();
        req = 4'b0000; int_branch = 0; int_branch_taken = 0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
    endtask

    int rec [8];
    int exp_seq [8];
    int g0, g1, w_first;
    logic [TAG_W-1:0] held_tag;

    initial begin
        for (int i = 0; i < 4; i++) begin tag[i] = '0; dat[i] = '0; end
        tick(); tick();
        mid();
        chk("reset_valid", 64'(cdb_valid), 64'd0);
        chk("reset_tag", 64'(cdb_tag), 64'd0);
        chk("reset_gnt", 64'(gnt_v), 64'd0);
        reset = 1'b0;
        tick();

        // Single int transfer with one-cycle broadcast latency
        tag[0] = 6'h05; dat[0] = 32'hDEADBEEF; req[0] = 1;
        mid();
        chk("single_gnt", 64'(int_gnt), 64'd1);
        tick(); req[0] = 0;
        mid();
        chk("single_valid", 64'(cdb_valid), 64'd1);
        chk("single_tag", 64'(cdb_tag), 64'h05);
        chk("single_data", 64'(cdb_data), 64'hDEADBEEF);
        tick(); mid();
        chk("single_idle", 64'(cdb_valid), 64'd0);

        // All four requesting for eight cycles
        do_reset();
        for (int i = 0; i < 4; i++) begin tag[i] = 6'(6'h10 + i); dat[i] = 32'h100 + 32'(i); end
        req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
`ifdef CDB_ARB_RR_EN
            exp_seq[i] = i % 4;
`else
            exp_seq[i] = 3;
`endif
        end
        for (int i = 0; i < 8; i++) begin
            mid();
            rec[i] = onehot_idx(gnt_v);
            chk("all4_seq", 64'(rec[i]), 64'(exp_seq[i]));
            if (i > 0) chk("all4_tag", 64'(cdb_tag), 64'(6'h10 + exp_seq[i-1]));
            tick();
        end
        req = 4'b0000;
        mid();
        chk("all4_last_valid", 64'(cdb_valid), 64'd1);
        chk("all4_last_tag", 64'(cdb_tag), 64'(6'h10 + exp_seq[7]));

        // Branch flags follow an int grant only
        do_reset();
        tag[0] = 6'h07; dat[0] = 32'h77; int_branch = 1; int_branch_taken = 1; req[0] = 1;
        mid();
        chk("br_gnt", 64'(int_gnt), 64'd1);
        tick();
        req[0] = 0; int_branch = 0; int_branch_taken = 0;
        tag[1] = 6'h08; dat[1] = 32'h88; req[1] = 1;
        mid();
        chk("br_flag", 64'(cdb_branch), 64'd1);
        chk("br_taken", 64'(cdb_branch_taken), 64'd1);
        chk("br_ls_gnt", 64'(ls_gnt), 64'd1);
        tick(); req[1] = 0;
        mid();
        chk("br_ls_flag", 64'(cdb_branch), 64'd0);
        chk("br_ls_tag", 64'(cdb_tag), 64'h08);

        // ls and div contending
        do_reset();
        tag[1] = 6'h41; dat[1] = 32'h4141; tag[3] = 6'h43; dat[3] = 32'h4343;
        req[1] = 1; req[3] = 1;
        mid(); g0 = onehot_idx(gnt_v);
        tick(); req[g0] = 0;
        mid(); g1 = onehot_idx(gnt_v);
        tick(); req = 4'b0000;
`ifdef CDB_ARB_RR_EN
        chk("pair_first", 64'(g0), 64'd1);
        chk("pair_second", 64'(g1), 64'd3);
`else
        chk("pair_first", 64'(g0), 64'd3);
        chk("pair_second", 64'(g1), 64'd1);
`endif

        // Reset pulse mid-cycle while mult is granted
        do_reset();
        tag[0] = 6'h30; dat[0] = 32'h3030; req[0] = 1;
        tick(); req[0] = 0;
        tag[2] = 6'h22; dat[2] = 32'h1234; req[2] = 1;
        mid();
        chk("rst_pre_gnt", 64'(mult_gnt), 64'd1);
        chk("rst_pre_valid", 64'(cdb_valid), 64'd1);
        reset = 1'b1;
        #1;
        chk("rst_gnt", 64'(gnt_v), 64'd0);
        chk("rst_valid", 64'(cdb_valid), 64'd0);
        chk("rst_tag", 64'(cdb_tag), 64'd0);
        #1;
        reset = 1'b0;
        tag[0] = 6'h31; dat[0] = 32'hAAAA0001; req[0] = 1;
        #1;
        w_first = onehot_idx(gnt_v);
`ifdef CDB_ARB_RR_EN
        chk("rst_first", 64'(w_first), 64'd0);
        held_tag = 6'h31;
`else
        chk("rst_first", 64'(w_first), 64'd2);
        held_tag = 6'h22;
`endif
        tick();
        chk("rst_no_stale", 64'(cdb_tag), 64'(held_tag));
        req = 4'b0000;

        // Idle: no grants, tag and data hold
        for (int i = 0; i < 5; i++) begin
            mid();
            chk("idle_gnt", 64'(gnt_v), 64'd0);
            if (i > 0) chk("idle_valid", 64'(cdb_valid), 64'd0);
            chk("idle_tag", 64'(cdb_tag), 64'(held_tag));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
